// File: rtl/dwt_sample_pairer_if.sv
// Sample-in / pair-out bundle between the EEG sample source, the pairer and the dwt stage.
// The slave modport is the pairer; the master modport is the surrounding logic (or bench).
interface dwt_sample_pairer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_ready;
  logic              pair_valid;
  logic [DATA_W-1:0] pair_a;
  logic [DATA_W-1:0] pair_b;
  logic              pair_last;
  logic              pair_pad;
  logic [IDX_W-1:0]  pair_idx;
  logic              coef_valid;
  logic              coef_last;
  logic [1:0]        dbg_state;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, pair_valid, pair_a, pair_b, pair_last, pair_pad, pair_idx,
           coef_valid, coef_last, dbg_state
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, pair_valid, pair_a, pair_b, pair_last, pair_pad, pair_idx,
           coef_valid, coef_last, dbg_state
  );
endinterface

// File: rtl/dwt_sample_pairer.sv
// Groups a serial signed sample stream into (even, odd) pairs for the dwt stage, pads
// odd-length frames by duplicating the last sample, and emits a coef sideband one cycle late.
//
// Handshakes: a sample moves when s_valid && s_ready on a rising clk edge; a pair moves when
// pair_valid && m_ready. Once raised, pair_valid and the pair fields hold until the pair moves.
// s_ready is combinational and may depend on m_ready; upstream must hold s_data while stalled.
module dwt_sample_pairer #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  dwt_sample_pairer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pair_a_q, pair_a_d;
  logic [DATA_W-1:0] pair_b_q, pair_b_d;
  logic              pair_last_q, pair_last_d;
  logic              pair_pad_q, pair_pad_d;
  logic [IDX_W-1:0]  pair_idx_q, pair_idx_d;
  logic              coef_valid_q, coef_last_q;
  logic              accept, xfer, pair_valid;

  assign pair_valid  = (state_q == FULL);
  assign bus.s_ready = rst_n && ((state_q != FULL) || bus.m_ready);
  assign accept      = bus.s_valid && bus.s_ready;
  assign xfer        = pair_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      pair_a_q     <= '0;
      pair_b_q     <= '0;
      pair_last_q  <= 1'b0;
      pair_pad_q   <= 1'b0;
      pair_idx_q   <= '0;
      coef_valid_q <= 1'b0;
      coef_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_a_q     <= pair_a_d;
      pair_b_q     <= pair_b_d;
      pair_last_q  <= pair_last_d;
      pair_pad_q   <= pair_pad_d;
      pair_idx_q   <= pair_idx_d;
      coef_valid_q <= xfer;
      coef_last_q  <= xfer && pair_last_q;
    end
  end

  // An accept while FULL implies a transfer in the same cycle (s_ready needs m_ready there),
  // so after the transfer clause FULL behaves exactly like EMPTY for the incoming sample.
  always_comb begin
    state_d     = state_q;
    pair_a_d    = pair_a_q;
    pair_b_d    = pair_b_q;
    pair_last_d = pair_last_q;
    pair_pad_d  = pair_pad_q;
    pair_idx_d  = pair_idx_q;

    if (xfer) begin
      state_d    = EMPTY;
      pair_idx_d = pair_last_q ? '0 : pair_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    end

    if (accept) begin
      case (state_q)
        HALF: begin
          pair_b_d    = bus.s_data;
          pair_last_d = bus.s_last;
          pair_pad_d  = 1'b0;
          state_d     = FULL;
        end
        EMPTY, FULL: begin
          pair_a_d = bus.s_data;
          if (bus.s_last) begin
            pair_b_d    = bus.s_data;
            pair_pad_d  = 1'b1;
            pair_last_d = 1'b1;
            state_d     = FULL;
          end else begin
            state_d = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign bus.pair_valid = pair_valid;
  assign bus.pair_a     = pair_a_q;
  assign bus.pair_b     = pair_b_q;
  assign bus.pair_last  = pair_last_q;
  assign bus.pair_pad   = pair_pad_q;
  assign bus.pair_idx   = pair_idx_q;
  assign bus.coef_valid = coef_valid_q;
  assign bus.coef_last  = coef_last_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_dwt_sample_pairer.sv
// Directed bench for dwt_sample_pairer: pair scoreboard, coef timing monitor and a small
// dwt average/difference model fed from the presented pairs.
module tb_dwt_sample_pairer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  dwt_sample_pairer_if #(.DATA_W(8), .IDX_W(8)) bus ();

  dwt_sample_pairer #(.DATA_W(8), .IDX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // pair entry: {last, pad, idx[7:0], a[7:0], b[7:0]}; coef entry: {avg[7:0], diff[7:0]}
  logic [25:0] exp_q[$];
  logic [15:0] coef_q[$];
  logic        prev_xfer, prev_last;
  logic [7:0]  dwt_avg, dwt_diff;

  // reference dwt: registered floor((a+b)/2) and floor((a-b)/2)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwt_avg  <= 8'h00;
      dwt_diff <= 8'h00;
    end else if (bus.pair_valid && bus.m_ready) begin
      dwt_avg  <= 8'(($signed({bus.pair_a[7], bus.pair_a}) + $signed({bus.pair_b[7], bus.pair_b})) >>> 1);
      dwt_diff <= 8'(($signed({bus.pair_a[7], bus.pair_a}) - $signed({bus.pair_b[7], bus.pair_b})) >>> 1);
    end
  end

  always @(negedge clk) begin
    logic [25:0] obs, exp_v;
    logic [15:0] cexp;
    logic        xfer_now;
    if (!rst_n) begin
      prev_xfer = 1'b0;
      prev_last = 1'b0;
    end else begin
      checks++;
      if (bus.coef_valid !== prev_xfer || bus.coef_last !== prev_last) begin
        errors++;
        $display("FAIL coef_timing: got valid=%b last=%b, want valid=%b last=%b",
                 bus.coef_valid, bus.coef_last, prev_xfer, prev_last);
      end
      if (bus.coef_valid === 1'b1) begin
        checks++;
        if (coef_q.size() == 0) begin
          errors++;
          $display("FAIL coef_unexpected: got avg=%0d diff=%0d, want none",
                   $signed(dwt_avg), $signed(dwt_diff));
        end else begin
          cexp = coef_q.pop_front();
          if ({dwt_avg, dwt_diff} !== cexp) begin
            errors++;
            $display("FAIL dwt_coef: got avg=%0d diff=%0d, want avg=%0d diff=%0d",
                     $signed(dwt_avg), $signed(dwt_diff), $signed(cexp[15:8]), $signed(cexp[7:0]));
          end
        end
      end
      xfer_now = bus.pair_valid && bus.m_ready;
      if (xfer_now) begin
        obs = {bus.pair_last, bus.pair_pad, bus.pair_idx, bus.pair_a, bus.pair_b};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pair_unexpected: got %h, want none", obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL pair: got last=%b pad=%b idx=%0d a=%0d b=%0d, want last=%b pad=%b idx=%0d a=%0d b=%0d",
                     obs[25], obs[24], obs[23:16], $signed(obs[15:8]), $signed(obs[7:0]),
                     exp_v[25], exp_v[24], exp_v[23:16], $signed(exp_v[15:8]), $signed(exp_v[7:0]));
          end
        end
      end
      prev_xfer = xfer_now;
      prev_last = xfer_now && bus.pair_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic last,
                           input logic pad, input logic [7:0] idx,
                           input logic [7:0] avg, input logic [7:0] diff);
    exp_q.push_back({last, pad, idx, a, b});
    coef_q.push_back({avg, diff});
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge, s_valid left high
  task automatic send(input logic [7:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0 for 50 cycles, want accept of %0d", $signed(d));
    end
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready: got %b, want 0", bus.s_ready);
    end
    checks++;
    if ({bus.pair_valid, bus.pair_a, bus.pair_b, bus.pair_last, bus.pair_pad, bus.pair_idx,
         bus.coef_valid, bus.coef_last, bus.dbg_state} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b a=%h b=%h last=%b pad=%b idx=%h cv=%b cl=%b st=%0d, want all 0",
               bus.pair_valid, bus.pair_a, bus.pair_b, bus.pair_last, bus.pair_pad, bus.pair_idx,
               bus.coef_valid, bus.coef_last, bus.dbg_state);
    end
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1 || bus.dbg_state !== 2'd0) begin
      errors++; $display("FAIL post_reset: got s_ready=%b state=%0d, want 1 and 0", bus.s_ready, bus.dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_even_frame();
    bus.m_ready = 1'b1;
    push_pair(8'd10, 8'd20, 1'b0, 1'b0, 8'd0, 8'd15, -8'sd5);
    push_pair(-8'sd30, 8'd40, 1'b1, 1'b0, 8'd1, 8'd5, -8'sd35);
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    checks++;
    if (bus.pair_valid !== 1'b1 || bus.pair_a !== 8'd10 || bus.pair_b !== 8'd20) begin
      errors++;
      $display("FAIL even_latency: got valid=%b a=%0d b=%0d, want 1 10 20",
               bus.pair_valid, $signed(bus.pair_a), $signed(bus.pair_b));
    end
    send(-8'sd30, 1'b0);
    send(8'd40, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || coef_q.size() != 0 || bus.pair_idx !== 8'd0) begin
      errors++;
      $display("FAIL even_drain: got pending=%0d/%0d idx=%0d, want 0/0 idx 0",
               exp_q.size(), coef_q.size(), bus.pair_idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_odd_frame();
    push_pair(8'd7, -8'sd8, 1'b0, 1'b0, 8'd0, -8'sd1, 8'd7);
    push_pair(8'd100, 8'd100, 1'b1, 1'b1, 8'd1, 8'd100, 8'd0);
    send(8'd7, 1'b0);
    send(-8'sd8, 1'b0);
    send(8'd100, 1'b1);
    idle();
    checks++;
    if (bus.pair_pad !== 1'b1 || bus.pair_last !== 1'b1 || bus.pair_b !== 8'd100) begin
      errors++;
      $display("FAIL odd_pad: got pad=%b last=%b b=%0d, want 1 1 100",
               bus.pair_pad, bus.pair_last, $signed(bus.pair_b));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || coef_q.size() != 0 || bus.pair_idx !== 8'd0) begin
      errors++;
      $display("FAIL odd_drain: got pending=%0d/%0d idx=%0d, want 0/0 idx 0",
               exp_q.size(), coef_q.size(), bus.pair_idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    push_pair(8'd1, 8'd2, 1'b0, 1'b0, 8'd0, 8'd1, -8'sd1);
    push_pair(8'd3, 8'd3, 1'b1, 1'b1, 8'd1, 8'd3, 8'd0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd3;
    bus.s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pair_valid !== 1'b1 || bus.pair_a !== 8'd1 || bus.pair_b !== 8'd2 || bus.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b a=%0d b=%0d s_ready=%b, want 1 1 2 0",
                 bus.pair_valid, $signed(bus.pair_a), $signed(bus.pair_b), bus.s_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b, want 1", bus.s_ready);
    end
    @(posedge clk);
    #1;
    idle();
    checks++;
    if (bus.pair_valid !== 1'b1 || bus.pair_a !== 8'd3 || bus.pair_pad !== 1'b1 || bus.pair_idx !== 8'd1) begin
      errors++;
      $display("FAIL bp_same_cycle: got valid=%b a=%0d pad=%b idx=%0d, want 1 3 1 1",
               bus.pair_valid, $signed(bus.pair_a), bus.pair_pad, bus.pair_idx);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || coef_q.size() != 0) begin
      errors++; $display("FAIL bp_drain: got pending=%0d/%0d, want 0/0", exp_q.size(), coef_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_extremes();
    push_pair(8'h80, 8'h7f, 1'b0, 1'b0, 8'd0, -8'sd1, 8'h80);
    push_pair(8'h80, 8'h80, 1'b1, 1'b0, 8'd1, 8'h80, 8'd0);
    send(8'h80, 1'b0);
    send(8'h7f, 1'b0);
    send(8'h80, 1'b0);
    send(8'h80, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || coef_q.size() != 0) begin
      errors++; $display("FAIL extremes_drain: got pending=%0d/%0d, want 0/0", exp_q.size(), coef_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // 257 pairs in one frame: idx runs 0..255 then wraps to 0 on the final pair
  task automatic test_idx_wrap();
    for (int k = 0; k < 257; k++) begin
      logic [7:0] a, b;
      int sa, sb;
      a  = 8'(2 * k);
      b  = 8'(2 * k + 1);
      sa = int'($signed(a));
      sb = int'($signed(b));
      push_pair(a, b, (k == 256), 1'b0, 8'(k), 8'((sa + sb) >>> 1), 8'((sa - sb) >>> 1));
    end
    for (int i = 0; i < 514; i++) begin
      send(8'(i), (i == 513));
    end
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || coef_q.size() != 0 || bus.pair_idx !== 8'd0) begin
      errors++;
      $display("FAIL wrap_drain: got pending=%0d/%0d idx=%0d, want 0/0 idx 0",
               exp_q.size(), coef_q.size(), bus.pair_idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    send(8'h80, 1'b0);
    idle();
    checks++;
    if (bus.dbg_state !== 2'd1 || bus.pair_a !== 8'h80) begin
      errors++; $display("FAIL mid_half: got state=%0d a=%h, want 1 80", bus.dbg_state, bus.pair_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pair_a !== 8'h00 || bus.pair_valid !== 1'b0 || bus.s_ready !== 1'b0 ||
        bus.dbg_state !== 2'd0 || bus.coef_valid !== 1'b0 || bus.pair_idx !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got a=%h valid=%b s_ready=%b state=%0d cv=%b idx=%0d, want 00 0 0 0 0 0",
               bus.pair_a, bus.pair_valid, bus.s_ready, bus.dbg_state, bus.coef_valid, bus.pair_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_pair(8'd5, 8'd6, 1'b1, 1'b0, 8'd0, 8'd5, -8'sd1);
    send(8'd5, 1'b0);
    send(8'd6, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || coef_q.size() != 0) begin
      errors++; $display("FAIL mid_drain: got pending=%0d/%0d, want 0/0", exp_q.size(), coef_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors      = 0;
    checks      = 0;
    prev_xfer   = 1'b0;
    prev_last   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_even_frame();
    test_odd_frame();
    test_backpressure();
    test_extremes();
    test_idx_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
